// File: rtl/centroid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : centroid_pkg
// Purpose  : Shared widths and FSM encoding for the colour centroid extractor.
// Revision : 1.0  initial release
// ============================================================================
package centroid_pkg;

    localparam int COORD_W  = 10;
    localparam int CNT_W    = 19;
    localparam int SUM_W    = 29;
    localparam int QUO_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/centroid_div.sv
`default_nettype none
// ============================================================================
// Module   : centroid_div
// Purpose  : Serial restoring divider, one quotient bit per cycle, MSB first.
// Revision : 1.0  initial release
// ============================================================================
module centroid_div
    import centroid_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SUM_W-1:0]    dividend,
    input  logic [CNT_W-1:0]    divisor,
    output logic [QUO_BITS-1:0] quotient,
    output logic                done
);

    logic [SUM_W-1:0]    r_rem;
    logic [SUM_W-1:0]    r_dvs;
    logic [QUO_BITS-1:0] r_quo;
    logic [3:0]          r_iter;
    logic                w_fits;
    logic [SUM_W-1:0]    w_diff;

    always_comb begin
        w_fits = (r_rem >= r_dvs);
        w_diff = r_rem - r_dvs;
    end

    // Divisor starts pre-shifted to the quotient MSB weight and walks right;
    // the quotient is known to fit in QUO_BITS so no overflow check is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
            r_iter <= '0;
        end else if (start) begin
            r_rem  <= dividend;
            r_dvs  <= SUM_W'({divisor, {(QUO_BITS-1){1'b0}}});
            r_quo  <= '0;
            r_iter <= 4'(QUO_BITS);
        end else if (r_iter != 4'd0) begin
            if (w_fits) begin
                r_rem <= w_diff;
            end
            r_quo  <= {r_quo[QUO_BITS-2:0], w_fits};
            r_dvs  <= r_dvs >> 1;
            r_iter <= r_iter - 4'd1;
        end
    end

    assign quotient = r_quo;
    // High during the final iteration; quotient is complete the cycle after.
    assign done     = (r_iter == 4'd1);

endmodule
`default_nettype wire

// File: rtl/color_centroid.sv
`default_nettype none
// ============================================================================
// Module   : color_centroid
// Purpose  : Per-frame centroid of mask-qualified pixels with held outputs.
// Revision : 1.0  initial release
// ============================================================================
module color_centroid #(
    parameter int MIN_PIXELS = 64,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_mask,
    input  logic               eof,
    output logic [COORD_W-1:0] X_center,
    output logic [COORD_W-1:0] Y_center,
    output logic               ready,
    output logic               center_valid,
    output logic               busy,
    output logic               frame_drop
);
    import centroid_pkg::CNT_W;
    import centroid_pkg::SUM_W;
    import centroid_pkg::QUO_BITS;
    import centroid_pkg::state_t;
    import centroid_pkg::IDLE;
    import centroid_pkg::DIV;
    import centroid_pkg::DONE;

    localparam logic [CNT_W-1:0] c_min_pixels = CNT_W'(MIN_PIXELS);

    logic [SUM_W-1:0]    r_sum_x, r_sum_y, w_sum_x_nxt, w_sum_y_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                w_hit;
    state_t              r_state, w_state_nxt;
    logic                w_start, w_reject, w_load, w_drop;
    logic [QUO_BITS-1:0] w_quo_x, w_quo_y;
    logic                w_done_x, w_done_y;

    always_comb begin
        w_hit       = pix_valid & pix_mask;
        w_sum_x_nxt = r_sum_x + (w_hit ? SUM_W'(pix_x) : '0);
        w_sum_y_nxt = r_sum_y + (w_hit ? SUM_W'(pix_y) : '0);
        w_cnt_nxt   = r_cnt + (w_hit ? CNT_W'(1) : '0);
    end

    // The eof-cycle pixel is already folded into the *_nxt values handed to
    // the divider, so clearing here loses nothing.
    always_ff @(posedge clk) begin
        if (rst || eof) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_cnt   <= '0;
        end else begin
            r_sum_x <= w_sum_x_nxt;
            r_sum_y <= w_sum_y_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reject    = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (eof) begin
                    if (w_cnt_nxt >= c_min_pixels) begin
                        w_start     = 1'b1;
                        w_state_nxt = DIV;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            DIV: begin
                w_drop = eof;
                if (w_done_x && w_done_y) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_drop      = eof;
                w_load      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            X_center     <= '0;
            Y_center     <= '0;
            ready        <= 1'b0;
            center_valid <= 1'b0;
            frame_drop   <= 1'b0;
        end else begin
            center_valid <= w_load | w_reject;
            frame_drop   <= w_drop;
            if (w_load) begin
                X_center <= w_quo_x[COORD_W-1:0];
                Y_center <= w_quo_y[COORD_W-1:0];
                ready    <= 1'b1;
            end else if (w_reject) begin
                ready    <= 1'b0;
            end
        end
    end

    assign busy = (r_state == DIV);

    centroid_div u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_sum_x_nxt),
        .divisor  (w_cnt_nxt),
        .quotient (w_quo_x),
        .done     (w_done_x)
    );

    centroid_div u_div_y (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_sum_y_nxt),
        .divisor  (w_cnt_nxt),
        .quotient (w_quo_y),
        .done     (w_done_y)
    );

endmodule
`default_nettype wire

// File: tb/tb_color_centroid.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_centroid
// Purpose  : Self-checking bench for color_centroid (thresholds 64 and 1).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_color_centroid;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_valid = 1'b0, pix_mask = 1'b0, eof = 1'b0;
    logic [9:0] pix_x = '0, pix_y = '0;
    logic [9:0] xc0, yc0, xc1, yc1;
    logic       rdy0, cv0, busy0, drop0, rdy1, cv1, busy1, drop1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    color_centroid dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_mask(pix_mask), .eof(eof), .X_center(xc0), .Y_center(yc0), .ready(rdy0),
        .center_valid(cv0), .busy(busy0), .frame_drop(drop0)
    );

    color_centroid #(.MIN_PIXELS(1)) dut1 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_mask(pix_mask), .eof(eof), .X_center(xc1), .Y_center(yc1), .ready(rdy1),
        .center_valid(cv1), .busy(busy1), .frame_drop(drop1)
    );

    // Reference model: plain frame sums plus the held result per instance.
    longint m_sx, m_sy, m_cnt;
    int     min_pix [2] = '{64, 1};
    int     exp_x [2], exp_y [2];
    bit     exp_rdy [2], exp_div [2];

    // Observation window results.
    int busy_n [2], cv_at [2], cv_n [2], drop_at [2], drop_n [2];
    bit rst_zero;

    function automatic logic [9:0] gx(input int d); return (d == 0) ? xc0 : xc1; endfunction
    function automatic logic [9:0] gy(input int d); return (d == 0) ? yc0 : yc1; endfunction
    function automatic logic       gr(input int d); return (d == 0) ? rdy0 : rdy1; endfunction

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        for (int d = 0; d < 2; d++) begin
            exp_x[d] = 0; exp_y[d] = 0; exp_rdy[d] = 1'b0; exp_div[d] = 1'b0;
        end
    endtask

    task automatic close_frame(input bit dropped);
        if (!dropped) begin
            for (int d = 0; d < 2; d++) begin
                exp_div[d] = (m_cnt >= longint'(min_pix[d]));
                if (exp_div[d]) begin
                    exp_x[d] = int'(m_sx / m_cnt);
                    exp_y[d] = int'(m_sy / m_cnt);
                end
                exp_rdy[d] = exp_div[d];
            end
        end
        m_sx = 0; m_sy = 0; m_cnt = 0;
    endtask

    task automatic drive_pix(input int x, input int y, input bit m, input bit v);
        @(negedge clk);
        eof = 1'b0; pix_valid = v; pix_mask = m; pix_x = 10'(x); pix_y = 10'(y);
        if (v && m) begin m_sx += x; m_sy += y; m_cnt++; end
    endtask

    task automatic drive_eof(input int x, input int y, input bit m, input bit v);
        @(negedge clk);
        eof = 1'b1; pix_valid = v; pix_mask = m; pix_x = 10'(x); pix_y = 10'(y);
        if (v && m) begin m_sx += x; m_sy += y; m_cnt++; end
        close_frame(1'b0);
    endtask

    // Index k = outputs seen after edge E0+k, where E0 sampled the eof.
    task automatic watch(input int n, input int eof2_at, input int rst_at);
        rst_zero = 1'b0;
        for (int d = 0; d < 2; d++) begin
            busy_n[d] = 0; cv_at[d] = -1; cv_n[d] = 0; drop_at[d] = -1; drop_n[d] = 0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (busy0) busy_n[0]++;
            if (busy1) busy_n[1]++;
            if (cv0) begin cv_n[0]++; if (cv_at[0] < 0) cv_at[0] = k; end
            if (cv1) begin cv_n[1]++; if (cv_at[1] < 0) cv_at[1] = k; end
            if (drop0) begin drop_n[0]++; if (drop_at[0] < 0) drop_at[0] = k; end
            if (drop1) begin drop_n[1]++; if (drop_at[1] < 0) drop_at[1] = k; end
            if (k == rst_at)
                rst_zero = ({xc0, yc0, rdy0, cv0, busy0, drop0,
                             xc1, yc1, rdy1, cv1, busy1, drop1} == '0);
            pix_valid = 1'b0; pix_mask = 1'b0;
            eof = (k + 1 == eof2_at);
            rst = (k + 1 == rst_at);
        end
        eof = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (xc0 !== 10'd0) begin errors++; $display("FAIL reset_x got %0d want 0", xc0); end
        checks++; if (yc0 !== 10'd0) begin errors++; $display("FAIL reset_y got %0d want 0", yc0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", rdy0); end
        checks++; if ({cv0, busy0, drop0} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {cv0, busy0, drop0}); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_single_pixel();
        drive_pix(5, 5, 1'b0, 1'b1);
        drive_pix(100, 200, 1'b1, 1'b1);
        drive_pix(7, 9, 1'b0, 1'b1);
        drive_eof(0, 0, 1'b0, 1'b0);
        watch(14, -1, -1);
        checks++; if (cv_at[1] !== 11) begin errors++; $display("FAIL single_latency got %0d want 11", cv_at[1]); end
        checks++; if (cv_n[1] !== 1) begin errors++; $display("FAIL single_cv_count got %0d want 1", cv_n[1]); end
        checks++; if (busy_n[1] !== 10) begin errors++; $display("FAIL single_busy_cycles got %0d want 10", busy_n[1]); end
        checks++; if ({xc1, yc1, rdy1} !== {10'd100, 10'd200, 1'b1}) begin errors++; $display("FAIL single_result got %0d,%0d,%0b want 100,200,1", xc1, yc1, rdy1); end
        checks++; if (cv_at[0] !== 0 || busy_n[0] !== 0 || rdy0 !== 1'b0) begin errors++; $display("FAIL single_min64_reject got cv_at %0d busy %0d ready %0b want 0,0,0", cv_at[0], busy_n[0], rdy0); end
    endtask

    task automatic test_block();
        for (int y = 100; y < 110; y++)
            for (int x = 300; x < 310; x++)
                if (!(x == 309 && y == 109)) drive_pix(x, y, 1'b1, 1'b1);
        drive_eof(309, 109, 1'b1, 1'b1);
        watch(14, -1, -1);
        checks++; if ({xc0, yc0, rdy0} !== {10'd304, 10'd104, 1'b1}) begin errors++; $display("FAIL block_result got %0d,%0d,%0b want 304,104,1", xc0, yc0, rdy0); end
        checks++; if (cv_at[0] !== 11 || cv_n[0] !== 1) begin errors++; $display("FAIL block_cv got at %0d n %0d want 11,1", cv_at[0], cv_n[0]); end
    endtask

    task automatic test_max_coord();
        for (int y = 416; y < 480; y++) drive_pix(639, y, 1'b1, 1'b1);
        drive_eof(0, 0, 1'b0, 1'b0);
        watch(14, -1, -1);
        checks++; if ({xc0, yc0} !== {10'd639, 10'd447}) begin errors++; $display("FAIL max_coord got %0d,%0d want 639,447", xc0, yc0); end
    endtask

    task automatic test_threshold();
        for (int i = 0; i < 63; i++) drive_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1);
        drive_eof(0, 0, 1'b0, 1'b0);
        watch(14, -1, -1);
        checks++; if (cv_at[0] !== 0 || cv_n[0] !== 1 || busy_n[0] !== 0) begin errors++; $display("FAIL thr63_timing got cv_at %0d n %0d busy %0d want 0,1,0", cv_at[0], cv_n[0], busy_n[0]); end
        checks++; if ({xc0, yc0, rdy0} !== {10'(exp_x[0]), 10'(exp_y[0]), 1'b0}) begin errors++; $display("FAIL thr63_hold got %0d,%0d,%0b want %0d,%0d,0", xc0, yc0, rdy0, exp_x[0], exp_y[0]); end
        checks++; if ({xc1, yc1, rdy1} !== {10'(exp_x[1]), 10'(exp_y[1]), 1'b1}) begin errors++; $display("FAIL thr63_min1 got %0d,%0d,%0b want %0d,%0d,1", xc1, yc1, rdy1, exp_x[1], exp_y[1]); end
        for (int i = 0; i < 63; i++) drive_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1);
        drive_eof($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1);
        watch(14, -1, -1);
        checks++; if ({xc0, yc0, rdy0} !== {10'(exp_x[0]), 10'(exp_y[0]), 1'b1} || cv_at[0] !== 11) begin errors++; $display("FAIL thr64_result got %0d,%0d,%0b at %0d want %0d,%0d,1 at 11", xc0, yc0, rdy0, cv_at[0], exp_x[0], exp_y[0]); end
    endtask

    task automatic test_empty();
        drive_eof(123, 45, 1'b0, 1'b1);
        watch(14, -1, -1);
        checks++; if (rdy1 !== 1'b0 || cv_at[1] !== 0 || busy_n[1] !== 0) begin errors++; $display("FAIL empty_frame got ready %0b cv_at %0d busy %0d want 0,0,0", rdy1, cv_at[1], busy_n[1]); end
        checks++; if ({xc1, yc1} !== {10'(exp_x[1]), 10'(exp_y[1])}) begin errors++; $display("FAIL empty_hold got %0d,%0d want %0d,%0d", xc1, yc1, exp_x[1], exp_y[1]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 100; i++) drive_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1);
        drive_eof(0, 0, 1'b0, 1'b0);
        watch(16, 5, -1);
        close_frame(1'b1);
        checks++; if (drop_at[0] !== 5 || drop_n[0] !== 1) begin errors++; $display("FAIL b2b_drop got at %0d n %0d want 5,1", drop_at[0], drop_n[0]); end
        checks++; if (cv_at[0] !== 11 || {xc0, yc0} !== {10'(exp_x[0]), 10'(exp_y[0])}) begin errors++; $display("FAIL b2b_result got %0d,%0d at %0d want %0d,%0d at 11", xc0, yc0, cv_at[0], exp_x[0], exp_y[0]); end
        checks++; if (drop_n[1] !== 1 || cv_n[1] !== 1) begin errors++; $display("FAIL b2b_min1 got drop %0d cv %0d want 1,1", drop_n[1], cv_n[1]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 80; i++) drive_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1);
        drive_eof(0, 0, 1'b0, 1'b0);
        watch(16, -1, 4);
        model_clear();
        checks++; if (rst_zero !== 1'b1) begin errors++; $display("FAIL rstmid_outputs got nonzero=%0b want zero", !rst_zero); end
        checks++; if (cv_n[0] !== 0 || cv_n[1] !== 0) begin errors++; $display("FAIL rstmid_cv got %0d,%0d want 0,0", cv_n[0], cv_n[1]); end
        for (int y = 56; y <= 64; y++)
            for (int x = 46; x <= 54; x++) drive_pix(x, y, 1'b1, 1'b1);
        drive_eof(0, 0, 1'b0, 1'b0);
        watch(14, -1, -1);
        checks++; if ({xc0, yc0, rdy0} !== {10'd50, 10'd60, 1'b1}) begin errors++; $display("FAIL rstmid_next got %0d,%0d,%0b want 50,60,1", xc0, yc0, rdy0); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(0, 160);
            for (int i = 0; i < n; i++)
                drive_pix($urandom_range(0, 639), $urandom_range(0, 479),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
            drive_eof($urandom_range(0, 639), $urandom_range(0, 479),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            watch(14, -1, -1);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (cv_at[d] !== (exp_div[d] ? 11 : 0) || cv_n[d] !== 1 || busy_n[d] !== (exp_div[d] ? 10 : 0) || drop_n[d] !== 0) begin
                    errors++; $display("FAIL rand_timing f%0d d%0d got cv_at %0d n %0d busy %0d drop %0d", f, d, cv_at[d], cv_n[d], busy_n[d], drop_n[d]);
                end
                checks++;
                if ({gx(d), gy(d), gr(d)} !== {10'(exp_x[d]), 10'(exp_y[d]), exp_rdy[d]}) begin
                    errors++; $display("FAIL rand_result f%0d d%0d got %0d,%0d,%0b want %0d,%0d,%0b", f, d, gx(d), gy(d), gr(d), exp_x[d], exp_y[d], exp_rdy[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_block();
        test_max_coord();
        test_threshold();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/color_centroid.md
# color_centroid

Per-frame centroid extractor for the tracked marker object. It accumulates the coordinates of every mask-qualified pixel in a 640x480 VGA frame. At end of frame it divides the sums by the pixel count in a shared serial divider and presents a held `X_center`/`Y_center` pair with `ready` to the gesture detectors (down/up/left/right action blocks). It sits between the colour-threshold stage of the VGA/camera pipeline and the gesture logic.

## Interface
Parameters:
- `MIN_PIXELS`, 64: minimum qualified-pixel count for a frame to produce a valid centroid.
- `COORD_W`, 10: coordinate width.

Ports:
- `clk`  in  1  pixel/system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `pix_valid`  in  1  active-area pixel strobe.
- `pix_x`  in  10  pixel column, 0..639.
- `pix_y`  in  10  pixel row, 0..479.
- `pix_mask`  in  1  pixel matches marker colour; only meaningful with `pix_valid`.
- `eof`  in  1  one-cycle end-of-frame pulse.
- `X_center`  out  10  held centroid column.
- `Y_center`  out  10  held centroid row.
- `ready`  out  1  level; high while the held centroid came from a frame with count >= `MIN_PIXELS`.
- `center_valid`  out  1  one-cycle pulse when `X_center`/`Y_center`/`ready` update.
- `busy`  out  1  divider running.
- `frame_drop`  out  1  one-cycle pulse when a frame's result is discarded.

## Operation
- Accumulators: `sum_x`, `sum_y` 29 bits; `cnt` 19 bits. Max values: 639*307200 and 307200, so no overflow and no saturation logic.
- A pixel with `pix_valid && pix_mask` adds `pix_x`, `pix_y` and 1. This applies in the `eof` cycle too, and that pixel belongs to the closing frame.
- On `eof`, the next-state sums and count are snapshotted and the accumulators clear to 0. The cleared value applies for the following cycle, so no pixel is lost or double-counted.
- FSM states:
  - IDLE:
    - On `eof` with snapshot `cnt >= MIN_PIXELS`, go to DIV.
    - On `eof` with `cnt < MIN_PIXELS`, stay in IDLE. Next cycle: `ready` <= 0, `center_valid` pulses, centres hold their previous values.
  - DIV: 10 restoring-division iterations, one quotient bit per cycle MSB first, x and y in parallel with divisor `cnt`. Quotient is floor; it is always < 640. Then go to DONE.
  - DONE: register quotients into `X_center`/`Y_center`, set `ready` <= 1, pulse `center_valid`, return to IDLE.
- `eof` while in DIV or DONE:
  - That frame is discarded and `frame_drop` pulses next cycle.
  - Accumulators still clear.
  - The in-flight division completes unaffected.
- `eof` with `pix_valid` and no prior pixels gives count 0 and follows the below-threshold path. The divider never sees divisor 0.
- Reset at any point:
  - All outputs go to 0: `X_center`=0, `Y_center`=0, `ready`=0, `center_valid`=0, `busy`=0, `frame_drop`=0.
  - Accumulators clear, FSM goes to IDLE, any in-flight division is abandoned.
  - `rst` has priority over `eof` in the same cycle.

## Timing
- `eof` sampled at edge E0. `busy` is high for cycles E0+1..E0+10. Outputs change and `center_valid` is high for the one cycle after edge E0+11.
- Total latency is 11 cycles from `eof` to new centroid.
- Below-threshold path: `ready` falls and `center_valid` pulses one cycle after `eof`.
- Minimum `eof` spacing for no drop is 12 cycles; real frames are far longer.
- `X_center`/`Y_center` are stable between `center_valid` pulses.

## Structure
- `centroid_pkg`: `COORD_W`, `CNT_W`=19, `SUM_W`=29, `QUO_BITS`=10, FSM state enum (IDLE, DIV, DONE).
- Sub-module `centroid_div`: serial restoring divider.
  - Ports: dividend `SUM_W`, divisor `CNT_W`, `start`, 10-bit `quotient`, `done`.
  - Instantiated twice (x, y), started together.

## Test plan
- `MIN_PIXELS`=1; one masked pixel at (100,200), then `eof` -> 11 cycles later `X_center`=100, `Y_center`=200, `ready`=1, `center_valid` one cycle.
- 10x10 masked block at x 300..309, y 100..109 -> x sum 30450/100 = floor 304, `Y_center`=104.
- Whole 640x480 frame masked -> `X_center`=319, `Y_center`=239; no overflow.
- 63 masked pixels, default `MIN_PIXELS` -> `ready` falls one cycle after `eof`, centres unchanged, `busy` never asserts.
- Second `eof` 5 cycles after the first -> `frame_drop` pulses once; the first result still appears at E0+11.
- `rst` asserted at E0+4 mid-division -> all outputs 0 next cycle, no `center_valid`; the next frame (block at 50,60) yields 50,60.
